// File: rtl/bsg_upscale_pkg.sv
// Shared types, constants and packing helpers for the upscale pixel feeder.
package bsg_upscale_pkg;

   localparam int pixel_width_lp        = 24;
   localparam int sof_bit_lp            = 79;
   localparam int img_width_default_lp  = 64;
   localparam int img_height_default_lp = 64;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_s;

   typedef enum logic {
      e_idle   = 1'b0,
      e_active = 1'b1
   } feeder_state_e;

   function automatic int words_per_row(input int width, input int per_word);
      return (width + per_word - 1) / per_word;
   endfunction

   function automatic int last_word_slots(input int width, input int per_word);
      return ((width % per_word) == 0) ? per_word : (width % per_word);
   endfunction

   // Counters never collapse to zero width, even for degenerate dimensions.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_upscale_pixel_feeder_if.sv
// Word-in / pixel-out bundle of the feeder; slave is the feeder, master drives words and yumi.
interface bsg_upscale_pixel_feeder_if #(
   parameter int data_width_p = 80
);
   logic [data_width_p-1:0] data_i;
   logic                    v_i;
   logic                    ready_o;
   logic [7:0]              r_o;
   logic [7:0]              g_o;
   logic [7:0]              b_o;
   logic                    v_o;
   logic                    yumi_i;
   logic                    sof_o;
   logic                    eol_o;
   logic                    eof_o;
   logic                    err_o;

   modport slave (
      input  data_i, v_i, yumi_i,
      output ready_o, r_o, g_o, b_o, v_o, sof_o, eol_o, eof_o, err_o
   );

   modport master (
      output data_i, v_i, yumi_i,
      input  ready_o, r_o, g_o, b_o, v_o, sof_o, eol_o, eof_o, err_o
   );
endinterface

// File: rtl/bsg_upscale_raster_counter.sv
// Raster position tracker (row/col/slot) with frame markers; shared with the output packer.
module bsg_upscale_raster_counter
   import bsg_upscale_pkg::*;
#(
   parameter int img_width_p       = img_width_default_lp,
   parameter int img_height_p      = img_height_default_lp,
   parameter int pixels_per_word_p = 3,
   localparam int slot_width_lp    = cnt_width(pixels_per_word_p)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     restart,
   input  logic                     advance,
   input  logic                     valid,
   output logic [slot_width_lp-1:0] slot,
   output logic                     last_slot,
   output logic                     sof,
   output logic                     eol,
   output logic                     eof
);

   localparam int col_width_lp = cnt_width(img_width_p);
   localparam int row_width_lp = cnt_width(img_height_p);

   logic [col_width_lp-1:0] col;
   logic [row_width_lp-1:0] row;
   logic                    col_end;
   logic                    row_end;
   logic                    slot_end;

   assign col_end  = (col  == col_width_lp'(img_width_p - 1));
   assign row_end  = (row  == row_width_lp'(img_height_p - 1));
   assign slot_end = (slot == slot_width_lp'(pixels_per_word_p - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         col  <= '0;
         row  <= '0;
         slot <= '0;
      end else if (restart) begin
         col  <= '0;
         row  <= '0;
         slot <= '0;
      end else if (advance) begin
         if (col_end) begin
            col  <= '0;
            slot <= '0;
            row  <= row_end ? '0 : row + 1'b1;
         end else begin
            col  <= col + 1'b1;
            slot <= slot_end ? '0 : slot + 1'b1;
         end
      end
   end

   // Words never straddle rows, so the row end also terminates the word.
   assign last_slot = col_end || slot_end;
   assign sof       = valid && (row == '0) && (col == '0);
   assign eol       = valid && col_end;
   assign eof       = eol && row_end;

endmodule

// File: rtl/bsg_upscale_pixel_feeder.sv
// Unpacks 80-bit network words into a one-pixel-per-cycle RGB stream with raster markers.
//   state    | meaning
//   e_idle   | waiting for a frame-start word; non-sof words are dropped and flagged
//   e_active | inside a frame; words are unpacked slot by slot until eof is consumed
module bsg_upscale_pixel_feeder
   import bsg_upscale_pkg::*;
#(
   parameter int data_width_p      = 80,
   parameter int pixels_per_word_p = 3,
   parameter int img_width_p       = img_width_default_lp,
   parameter int img_height_p      = img_height_default_lp
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   bsg_upscale_pixel_feeder_if.slave    bus
);

   localparam int pixel_bits_lp = pixels_per_word_p * pixel_width_lp;
   localparam int slot_width_lp = cnt_width(pixels_per_word_p);

   feeder_state_e            state_r, state_n, dec_state;
   logic [pixel_bits_lp-1:0] word_r, word_n;
   logic                     held_r, held_n;
   logic                     err_r, err_n;
   logic                     restart;
   logic                     consume;
   logic                     accept;
   logic                     ready;
   logic [slot_width_lp-1:0] slot;
   logic                     last_slot;
   logic                     sof;
   logic                     eol;
   logic                     eof;
   pixel_s                   slots [pixels_per_word_p];
   pixel_s                   pix;
   logic                     unused_reserved;

   assign unused_reserved = ^bus.data_i[sof_bit_lp-1:pixel_bits_lp];

   assign consume = held_r && bus.yumi_i;
   assign ready   = !held_r || (consume && last_slot);
   assign accept  = bus.v_i && ready;

   bsg_upscale_raster_counter #(
      .img_width_p       (img_width_p),
      .img_height_p      (img_height_p),
      .pixels_per_word_p (pixels_per_word_p)
   ) raster (
      .clk       (clk_i),
      .reset_n   (reset_n_i),
      .restart   (restart),
      .advance   (consume),
      .valid     (held_r),
      .slot      (slot),
      .last_slot (last_slot),
      .sof       (sof),
      .eol       (eol),
      .eof       (eof)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= e_idle;
         word_r  <= '0;
         held_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         word_r  <= word_n;
         held_r  <= held_n;
         err_r   <= err_n;
      end
   end

   always_comb begin
      state_n   = state_r;
      word_n    = word_r;
      held_n    = held_r;
      err_n     = err_r;
      restart   = 1'b0;
      dec_state = state_r;

      if (consume && last_slot) held_n = 1'b0;

      // A word arriving as eof leaves is decoded as if already idle.
      if (consume && eof) begin
         dec_state = e_idle;
         state_n   = e_idle;
      end

      if (accept) begin
         if (bus.data_i[sof_bit_lp]) begin
            // Active at accept time always means the frame is past (0,0).
            if (dec_state == e_active) err_n = 1'b1;
            restart = 1'b1;
            state_n = e_active;
            held_n  = 1'b1;
            word_n  = bus.data_i[pixel_bits_lp-1:0];
         end else if (dec_state == e_idle) begin
            err_n = 1'b1;
         end else begin
            held_n = 1'b1;
            word_n = bus.data_i[pixel_bits_lp-1:0];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < pixels_per_word_p; k++) begin
         slots[k] = word_r[k*pixel_width_lp +: pixel_width_lp];
      end
   end

   assign pix         = slots[slot];
   assign bus.r_o     = pix.r;
   assign bus.g_o     = pix.g;
   assign bus.b_o     = pix.b;
   assign bus.v_o     = held_r;
   assign bus.ready_o = ready;
   assign bus.sof_o   = sof;
   assign bus.eol_o   = eol;
   assign bus.eof_o   = eof;
   assign bus.err_o   = err_r;

endmodule

// File: tb/tb_bsg_upscale_pixel_feeder.sv
// Self-checking bench: nominal vector table, directed corner sequences and a random word-stream model.
module tb_bsg_upscale_pixel_feeder;
   import bsg_upscale_pkg::*;

   localparam int W   = 4;
   localparam int H   = 2;
   localparam int PPW = 3;
   localparam int DW  = 80;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bsg_upscale_pixel_feeder_if #(.data_width_p(DW)) bus ();

   bsg_upscale_pixel_feeder #(
      .data_width_p      (DW),
      .pixels_per_word_p (PPW),
      .img_width_p       (W),
      .img_height_p      (H)
   ) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [23:0] pix;
      logic        sof;
      logic        eol;
      logic        eof;
      logic        last;
   } exp_pix_t;

   typedef struct {
      logic        v;
      logic [79:0] d;
      logic        y;
      logic        e_v;
      logic        e_ready;
      logic [23:0] e_pix;
      logic [2:0]  e_mark;
   } vec_t;

   exp_pix_t    exp_q[$];
   logic [79:0] send_q[$];
   logic        m_err;
   logic        m_in_frame;
   int          m_row;
   int          m_col;

   vec_t        tbl[10];
   logic [79:0] w0, w1, w2, w3, stray;
   logic [23:0] nom_pix[3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [79:0] mk_word(input logic sof, input logic [23:0] p0,
                                          input logic [23:0] p1, input logic [23:0] p2);
      return {sof, 7'h55, p2, p1, p0};
   endfunction

   function automatic vec_t mk_vec(input logic v, input logic [79:0] d, input logic y,
                                   input logic ev, input logic er, input logic [23:0] p,
                                   input logic [2:0] m);
      vec_t t;
      t.v = v; t.d = d; t.y = y; t.e_v = ev; t.e_ready = er; t.e_pix = p; t.e_mark = m;
      return t;
   endfunction

   task automatic drive(input logic v, input logic [79:0] d, input logic y);
      bus.v_i    = v;
      bus.data_i = d;
      bus.yumi_i = y;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset_n = 1'b0;
      drive(1'b0, '0, 1'b0);
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("reset_v", bus.v_o, 1'b0);
      check("reset_err", bus.err_o, 1'b0);
      check("reset_ready", bus.ready_o, 1'b1);
   endtask

   task automatic model_reset();
      exp_q.delete();
      send_q.delete();
      m_err      = 1'b0;
      m_in_frame = 1'b0;
      m_row      = 0;
      m_col      = 0;
   endtask

   // Word-level model: a word contributes the pixels that fit in the rest of its row.
   task automatic model_accept(input logic [79:0] w);
      int n;
      exp_pix_t e;
      if (w[79]) begin
         if (m_in_frame) m_err = 1'b1;
         m_in_frame = 1'b1;
         m_row = 0;
         m_col = 0;
      end else if (!m_in_frame) begin
         m_err = 1'b1;
         return;
      end
      n = (W - m_col < PPW) ? (W - m_col) : PPW;
      for (int k = 0; k < n; k++) begin
         e.pix  = w[24*k +: 24];
         e.sof  = (m_row == 0) && (m_col + k == 0);
         e.eol  = (m_col + k == W - 1);
         e.eof  = e.eol && (m_row == H - 1);
         e.last = (k == n - 1);
         exp_q.push_back(e);
      end
      m_col += n;
      if (m_col == W) begin
         m_col = 0;
         m_row++;
         if (m_row == H) begin
            m_row = 0;
            m_in_frame = 1'b0;
         end
      end
   endtask

   task automatic run(input int ymode, input int vmode, input int budget);
      int          cyc = 0;
      logic        stall = 1'b0;
      logic [27:0] prev = '0;
      logic [27:0] cur;
      logic        v, y;
      logic [95:0] junk;
      logic [79:0] d;
      while ((send_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         v = (send_q.size() > 0) && (vmode == 0 || $urandom_range(0, 3) != 0);
         case (ymode)
            0:       y = 1'b1;
            1:       y = cyc[0];
            default: y = ($urandom_range(0, 2) != 0);
         endcase
         y = y && bus.v_o;
         junk = {$urandom(), $urandom(), $urandom()};
         d = v ? send_q[0] : junk[79:0];
         drive(v, d, y);
         #1;
         cur = {bus.v_o, bus.sof_o, bus.eol_o, bus.eof_o, bus.r_o, bus.g_o, bus.b_o};
         if (stall) check("stall_hold", cur, prev);
         check("err", bus.err_o, m_err);
         if (bus.v_o) begin
            check("pixel_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               check("pix", {bus.r_o, bus.g_o, bus.b_o}, exp_q[0].pix);
               check("markers", {bus.sof_o, bus.eol_o, bus.eof_o},
                     {exp_q[0].sof, exp_q[0].eol, exp_q[0].eof});
               check("ready_held", bus.ready_o, y && exp_q[0].last);
               if (y) void'(exp_q.pop_front());
            end
         end else begin
            check("ready_empty", bus.ready_o, 1'b1);
         end
         stall = bus.v_o && !y;
         prev  = cur;
         if (v && bus.ready_o) model_accept(send_q.pop_front());
      end
      check("run_budget", cyc < budget, 1'b1);
      @(negedge clk);
      drive(1'b0, '0, 1'b0);
      #1;
      check("drained_v", bus.v_o, 1'b0);
   endtask

   task automatic gen_frames(input int nframes);
      int          kind, nwords, limit;
      logic [95:0] t;
      logic [79:0] w;
      nwords = words_per_row(W, PPW) * H;
      for (int f = 0; f < nframes; f++) begin
         kind = $urandom_range(0, 7);
         if (kind == 0) begin
            t = {$urandom(), $urandom(), $urandom()};
            w = t[79:0];
            w[79] = 1'b0;
            send_q.push_back(w);
         end else begin
            limit = (kind == 1) ? $urandom_range(1, nwords - 1) : nwords;
            for (int j = 0; j < limit; j++) begin
               t = {$urandom(), $urandom(), $urandom()};
               w = t[79:0];
               w[79] = (j == 0);
               send_q.push_back(w);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, '0, 1'b0);
      w0    = mk_word(1'b1, 24'h010203, 24'h040506, 24'h070809);
      w1    = mk_word(1'b0, 24'h0A0B0C, 24'hDEAD01, 24'hDEAD02);
      w2    = mk_word(1'b0, 24'h0D0E0F, 24'h101112, 24'h131415);
      w3    = mk_word(1'b0, 24'h161718, 24'hDEAD03, 24'hDEAD04);
      stray = mk_word(1'b0, 24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC);
      nom_pix[0] = 24'h010203;
      nom_pix[1] = 24'h040506;
      nom_pix[2] = 24'h070809;

      // v, data, yumi | v_o, ready_o, pixel, {sof,eol,eof}
      tbl[0] = mk_vec(1, w0, 0, 0, 1, 24'h0,      3'b000);
      tbl[1] = mk_vec(1, w1, 1, 1, 0, 24'h010203, 3'b100);
      tbl[2] = mk_vec(1, w1, 1, 1, 0, 24'h040506, 3'b000);
      tbl[3] = mk_vec(1, w1, 1, 1, 1, 24'h070809, 3'b000);
      tbl[4] = mk_vec(1, w2, 1, 1, 1, 24'h0A0B0C, 3'b010);
      tbl[5] = mk_vec(1, w3, 1, 1, 0, 24'h0D0E0F, 3'b000);
      tbl[6] = mk_vec(1, w3, 1, 1, 0, 24'h101112, 3'b000);
      tbl[7] = mk_vec(1, w3, 1, 1, 1, 24'h131415, 3'b000);
      tbl[8] = mk_vec(0, '0, 1, 1, 1, 24'h161718, 3'b011);
      tbl[9] = mk_vec(0, '0, 0, 0, 1, 24'h0,      3'b000);

      do_reset(2);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].d, tbl[i].y);
         #1;
         check($sformatf("nom[%0d].v", i), bus.v_o, tbl[i].e_v);
         check($sformatf("nom[%0d].ready", i), bus.ready_o, tbl[i].e_ready);
         check($sformatf("nom[%0d].err", i), bus.err_o, 1'b0);
         if (tbl[i].e_v) begin
            check($sformatf("nom[%0d].pix", i), {bus.r_o, bus.g_o, bus.b_o}, tbl[i].e_pix);
            check($sformatf("nom[%0d].mark", i), {bus.sof_o, bus.eol_o, bus.eof_o}, tbl[i].e_mark);
         end
      end

      // backpressure with alternating yumi
      model_reset();
      send_q = '{w0, w1, w2, w3};
      run(1, 0, 200);

      // frame not preceded by sof
      do_reset(1);
      model_reset();
      send_q = '{stray, w0, w1, w2, w3};
      run(0, 0, 200);
      check("missing_sof_err_sticky", bus.err_o, 1'b1);

      // second sof mid-frame
      do_reset(1);
      model_reset();
      send_q = '{w0, w1, w2, w0, w1, w2, w3};
      run(0, 0, 200);
      check("early_sof_err", bus.err_o, 1'b1);

      // reset with a word held mid-frame
      do_reset(1);
      model_reset();
      @(negedge clk);
      drive(1'b1, w0, 1'b0);
      #1;
      check("mid_ready", bus.ready_o, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(i == 2, (i == 2) ? w1 : 80'h0, 1'b1);
         #1;
         check("mid_pix", {bus.r_o, bus.g_o, bus.b_o}, nom_pix[i]);
      end
      do_reset(1);
      model_reset();
      send_q = '{w0, w1, w2, w3};
      run(0, 0, 200);

      // random streams with occasional missing / truncated frames
      for (int r = 0; r < 8; r++) begin
         gen_frames(5);
         run(2, 1, 4000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
